// File: rtl/muldiv_seq_unit_if.sv
// Handshake and operand bundle for muldiv_seq_unit.
// The master is the issuing pipeline stage; the slave is the multiply/divide unit.
interface muldiv_seq_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output in_valid, funct3, src_a, src_b, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, funct3, src_a, src_b, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/muldiv_seq_unit.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_EARLY_OUT_EN to resolve divide-by-zero, signed overflow and zero multiplies in IDLE.
module muldiv_seq_unit #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned CNTW = $clog2(XLEN)
) (
   input  logic                clk,
   input  logic                rst,
   muldiv_seq_unit_if.slave    bus
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StFix  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state_q, state_d;
   logic [2:0]        f3_q, f3_d;
   logic              sign_a_q, sign_a_d;
   logic              sign_b_q, sign_b_d;
   logic              dz_q, dz_d;
   logic              ovf_q, ovf_d;
   logic [XLEN-1:0]   a_raw_q, a_raw_d;
   logic [XLEN-1:0]   opd_q, opd_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              in_div, sa_en, sb_en, neg_a, neg_b, in_dz, in_ovf;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     sum, trial;
   logic [2*XLEN-1:0] prod_n;
   logic [XLEN-1:0]   quot_n, rem_n, fix_res;

   // Architected result for the cases the iterative datapath gets wrong or need not compute.
   function automatic logic [XLEN-1:0] corner_res(input logic [2:0] f3, input logic dz,
                                                  input logic [XLEN-1:0] a);
      if (!f3[2]) return '0;
      if (f3[1])  return dz ? a : '0;
      return dz ? '1 : a;
   endfunction

   always_comb begin
      in_div = bus.funct3[2];
      sa_en  = in_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
      sb_en  = in_div ? ~bus.funct3[0] : ~bus.funct3[1];
      neg_a  = sa_en & bus.src_a[XLEN-1];
      neg_b  = sb_en & bus.src_b[XLEN-1];
      mag_a  = neg_a ? -bus.src_a : bus.src_a;
      mag_b  = neg_b ? -bus.src_b : bus.src_b;
      in_dz  = in_div & (bus.src_b == '0);
      in_ovf = in_div & ~bus.funct3[0] & (bus.src_a == MinInt) & (bus.src_b == '1);
   end

   always_comb begin
      sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q};
      // Shifted partial remainder minus divisor; bit XLEN is the borrow.
      trial  = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opd_q};
      prod_n = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
      quot_n = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_n  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      unique case (f3_q)
         3'b000:                 fix_res = prod_n[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_res = prod_n[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_res = quot_n;
         default:                fix_res = rem_n;
      endcase
      if (dz_q || ovf_q) fix_res = corner_res(f3_q, dz_q, a_raw_q);
   end

   always_comb begin
      state_d  = state_q;
      f3_d     = f3_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      a_raw_d  = a_raw_q;
      opd_d    = opd_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               f3_d     = bus.funct3;
               sign_a_d = neg_a;
               sign_b_d = neg_b;
               dz_d     = in_dz;
               ovf_d    = in_ovf;
               a_raw_d  = bus.src_a;
               opd_d    = in_div ? mag_b : mag_a;
               acc_d    = {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
               cnt_d    = CNTW'(XLEN - 1);
`ifdef MULDIV_EARLY_OUT_EN
               if (in_dz || in_ovf ||
                   (!in_div && ((bus.src_a == '0) || (bus.src_b == '0)))) begin
                  result_d = corner_res(bus.funct3, in_dz, bus.src_a);
                  state_d  = StDone;
               end else begin
                  state_d  = StCalc;
               end
`else
               state_d  = StCalc;
`endif
            end
         end
         StCalc: begin
            if (!f3_q[2]) begin
               acc_d = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
            end else if (!trial[XLEN]) begin
               acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
               acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end
            if (cnt_q == '0) state_d = StFix;
            else             cnt_d   = cnt_q - CNTW'(1);
         end
         StFix: begin
            result_d = fix_res;
            state_d  = StDone;
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         f3_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         a_raw_q  <= '0;
         opd_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         f3_q     <= f3_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
         a_raw_q  <= a_raw_d;
         opd_q    <= opd_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.busy      = (state_q == StCalc) || (state_q == StFix);
   assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Scoreboard bench for muldiv_seq_unit at XLEN=32; follows MULDIV_EARLY_OUT_EN for latency.
module tb_muldiv_seq_unit;

   localparam int unsigned XLEN   = 32;
   localparam int          LIMIT  = 200;
   localparam logic [31:0] MINV   = 32'h8000_0000;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   logic [31:0] exp_q[$];

   muldiv_seq_unit_if #(.XLEN(XLEN)) bus ();

   muldiv_seq_unit #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic signed [31:0] sa32, sb32;
      logic [63:0] ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      sa32 = a;
      sb32 = b;
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * $signed(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
            return sa32 / sb32;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
            return sa32 % sb32;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      logic early;
      early = f3[2] ? ((b == 0) || (!f3[0] && a == MINV && b == 32'hFFFF_FFFF))
                    : ((a == 0) || (b == 0));
`ifdef MULDIV_EARLY_OUT_EN
      return early ? 1 : XLEN + 2;
`else
      return (early && 1'b0) ? 1 : XLEN + 2;
`endif
   endfunction

   // Issue one op, wait for its result, optionally stall the consumer for hold cycles.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
      int n;
      int busy_n;
      int lat;
      logic [31:0] exp;
      lat = exp_latency(f3, a, b);
      exp_q.push_back(ref_model(f3, a, b));
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.funct3   = f3;
      bus.src_a    = a;
      bus.src_b    = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.funct3   = ~f3;
      bus.src_a    = ~a;
      bus.src_b    = ~b;
      n = 0;
      busy_n = 0;
      while (n < LIMIT) begin
         @(negedge clk);
         n++;
         if (bus.out_valid) break;
         if (bus.busy) busy_n++;
      end
      exp = exp_q.pop_front();
      if (!bus.out_valid) begin
         check("timeout", 64'(n), 64'(lat));
         return;
      end
      check("latency", 64'(n), 64'(lat));
      check("busy_cycles", 64'(busy_n), 64'(lat - 1));
      check("result", 64'(bus.result), 64'(exp));
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.funct3   = 3'd0;
         bus.src_a    = 32'd1;
         bus.src_b    = 32'd1;
         @(negedge clk);
         check("hold", {30'd0, bus.out_valid, bus.in_ready, bus.result}, {30'd0, 2'b10, exp});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("ready_after", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.funct3    = 3'd0;
      bus.src_a     = '0;
      bus.src_b     = '0;
      #2 rst = 1'b0;
      #1;
      check("reset_outputs", {31'd0, bus.out_valid, bus.busy, bus.result}, 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset_in_ready", 64'(bus.in_ready), 64'd1);

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(3'd1, MINV, MINV, 0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
      run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 0);
      run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 0);
      run_op(3'd5, 32'd20, 32'd3, 0);
      run_op(3'd7, 32'd20, 32'd3, 0);
      run_op(3'd4, MINV, 32'hFFFF_FFFF, 0);
      run_op(3'd6, MINV, 32'hFFFF_FFFF, 0);
      run_op(3'd5, 32'd5, 32'd0, 0);
      run_op(3'd7, 32'd5, 32'd0, 0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 0);
      run_op(3'd0, 32'd0, 32'd12345, 0);
      for (int i = 0; i < 8; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = (i % 3 == 0) ? $urandom_range(1, 9) : $urandom;
         run_op(3'($urandom_range(0, 7)), ra, rb, 0);
      end

      // Abandon a DIV mid-flight with an asynchronous reset.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.funct3   = 3'd4;
      bus.src_a    = 32'hFFFF_FFEC;
      bus.src_b    = 32'd3;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (15) @(negedge clk);
      check("busy_before_rst", 64'(bus.busy), 64'd1);
      rst = 1'b0;
      #1;
      check("rst_abort", {31'd0, bus.out_valid, bus.busy, bus.result}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      run_op(3'd0, 32'd3, 32'd4, 0);

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Multi-cycle integer multiply/divide unit for the RV32M/RV64M M-extension, parametrised in operand width.
- Sits beside the single-cycle ALU in the execute stage; the control unit routes op=0110011 with funct7=0000001 here.
- Each operation takes XLEN+2 cycles; valid/ready handshakes on input and output.
- Iterative radix-2: shift-add for multiply, restoring division for divide.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNTW, $clog2(XLEN), iteration counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept; high only in IDLE
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src_a  input  XLEN  rs1 operand
- src_b  input  XLEN  rs2 operand
- out_valid  output  1  result available; high only in DONE
- out_ready  input  1  consumer accepts result
- result  output  XLEN  registered result; stable while out_valid=1
- busy  output  1  high in CALC or FIX, for pipeline stall

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - result=0, out_valid=0, busy=0; in_ready=1 after reset release.
  - All internal registers are cleared.
  - Reset mid-operation abandons the operation; no result is produced.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch funct3 and operand magnitudes, compute sign flags, load counter=XLEN-1, go to CALC.
  - Magnitudes are abs() for signed operands and the raw value for unsigned ones.
  - MULHSU treats src_a as signed and src_b as unsigned.
- CALC: one step per cycle.
  - Multiply: if multiplier LSB=1, add multiplicand into the upper half of the 2*XLEN accumulator, then shift right 1.
  - Divide: shift {rem,quot} left 1, trial-subtract the divisor, set the quotient LSB if there is no borrow.
  - When counter=0, go to FIX; otherwise decrement the counter.
- FIX: one cycle.
  - Conditionally two's-complement negate: product if sign_a^sign_b; quotient if sign_a^sign_b; remainder if sign_a.
  - Select the result field:
    - MUL: low half of the product.
    - MULH/MULHSU/MULHU: high half of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register the result and go to DONE.
- DONE:
  - out_valid=1 and result is held.
  - On out_ready=1, go to IDLE; in_ready rises the next cycle, so there is no same-cycle accept.
  - out_ready=0 holds the state indefinitely.
- Latency: request accepted at edge E0 gives out_valid=1 from edge E0+XLEN+2 (34 for XLEN=32).
  - Throughput is one operation per XLEN+3 cycles with out_ready tied high.
- Inputs are ignored outside IDLE; src_a/src_b may change after acceptance.
- Division by zero (per RISC-V spec, no trap):
  - quotient = all ones (DIV and DIVU).
  - remainder = src_a.
- Signed overflow: DIV of -2^(XLEN-1) by -1 gives quotient = -2^(XLEN-1) and remainder = 0.
- Both corner results are forced in FIX, overriding the datapath value.
- Arithmetic: the accumulator is 2*XLEN bits and the trial subtraction is XLEN+1 bits; all wrap-around is modulo 2^XLEN on the selected field.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, detect divide-by-zero, signed overflow, or a multiply with either operand = 0.
  - Load the architected result directly and go to DONE, skipping CALC/FIX.
  - out_valid=1 from edge E0+1.
- Not defined: these cases take the full XLEN+2 latency; FIX still forces the corner values.
- Results are identical in both builds; only timing differs.

Test Plan:
- MUL 7 x -3 (src_b=0xFFFFFFFD), XLEN=32 -> result=0xFFFFFFEB, out_valid at E0+34, busy high for cycles 1..33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -20/3 -> 0xFFFFFFFA (-6); REM -20/3 -> 0xFFFFFFFE (-2); DIVU 20/3 -> 6; REMU 20/3 -> 2.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5.
  - With MULDIV_EARLY_OUT_EN: out_valid at E0+1.
  - Without it: out_valid at E0+34.
- Hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, in_valid ignored; then out_ready=1 for one cycle -> in_ready=1 the next cycle.
- Assert rst=0 at cycle 15 of a DIV -> outputs zero immediately (async); after release in_ready=1, and a new MUL 3x4 completes with result=12.
